// File: rtl/mp_pkg.sv
// Shared encodings and helpers for the multi-precision add/sub datapath.
package mp_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_CSUB = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Slice index width; at least one bit so a single-slice build still has an index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mp_chunk_add.sv
// Combinational CHUNK-bit adder with optional B inversion for two's-complement subtract.
module mp_chunk_add #(
    parameter int unsigned CHUNK = 128
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             inv_b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK-1:0] b_eff;

    always_comb begin
        b_eff       = inv_b ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential multi-precision add / sub / conditional-sub, one CHUNK-bit slice per cycle
// through a single shared adder, with a start/done handshake.
module mp_addsub_seq
    import mp_pkg::*;
#(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned CHUNK = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("mp_addsub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cin_q, cin_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic [CHUNK-1:0] a_slice, b_slice, sum;
    logic             cout;
    logic             sub_run;
    logic             accept;

    assign sub_run = (mode_q == MODE_SUB) || (mode_q == MODE_CSUB);
    assign a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign b_slice = b_q[idx_q*CHUNK +: CHUNK];

    mp_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a     (a_slice),
        .b     (b_slice),
        .inv_b (sub_run),
        .cin   (cin_q),
        .sum   (sum),
        .cout  (cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cin_d    = cin_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        accept   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = sum;
                cin_d = cout;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    carry_d = sub_run ? ~cout : cout;
                    // A borrow out of the top slice means A < M: keep A unreduced.
                    if ((mode_q == MODE_CSUB) && !cout) begin
                        result_d = a_q;
                    end
                end
            end
            ST_DONE: begin
                accept = start;
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_RUN;
            a_d     = in_a;
            b_d     = in_b;
            mode_d  = mode_e'(mode);
            idx_d   = '0;
            cin_d   = (mode == MODE_SUB) || (mode == MODE_CSUB);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cin_q    <= 1'b0;
            mode_q   <= MODE_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cin_q    <= cin_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Scoreboard bench: directed operations on a 4-slice and a 1-slice instance.
module tb_mp_addsub_seq;

    localparam int W = 512;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        int           c0;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic         start1 = 1'b0, start2 = 1'b0;
    logic [1:0]   mode1 = 2'b00, mode2 = 2'b00;
    logic [W-1:0] a1 = '0, b1 = '0, a2 = '0, b2 = '0;
    logic         busy1, done1, cy1, busy2, done2, cy2;
    logic [W-1:0] res1, res2;

    exp_t q1[$];
    exp_t q2[$];

    localparam logic [W-1:0] ALL1 = {W{1'b1}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mp_addsub_seq #(.WIDTH(W), .CHUNK(128)) dut4 (
        .clk (clk), .resetn (resetn), .start (start1), .mode (mode1),
        .in_a (a1), .in_b (b1), .busy (busy1), .done (done1),
        .result (res1), .carry_out (cy1)
    );

    mp_addsub_seq #(.WIDTH(W), .CHUNK(512)) dut1 (
        .clk (clk), .resetn (resetn), .start (start2), .mode (mode2),
        .in_a (a2), .in_b (b2), .busy (busy2), .done (done2),
        .result (res2), .carry_out (cy2)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents done.
    always @(negedge clk) begin
        if (resetn && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_done_c128", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("result_c128", res1, e.res);
                check("carry_c128", {511'b0, cy1}, {511'b0, e.cy});
                check("latency_c128", W'(cyc - e.c0), W'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("unexpected_done_c512", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("result_c512", res2, e.res);
                check("carry_c512", {511'b0, cy2}, {511'b0, e.cy});
                check("latency_c512", W'(cyc - e.c0), W'(e.lat));
            end
        end
    end

    // Drives start for one cycle at a negedge; optionally pushes the expectation.
    task automatic issue1(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic push, input logic [W-1:0] er, input logic ec);
        exp_t e;
        start1 = 1'b1;
        mode1 = m;
        a1 = a;
        b1 = b;
        if (push) begin
            e.res = er; e.cy = ec; e.c0 = cyc + 1; e.lat = 4;
            q1.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_drain1();
        for (int i = 0; i < 40; i++) begin
            if (q1.size() == 0 && !busy1 && !done1) break;
            @(negedge clk);
        end
        if (q1.size() != 0 || busy1 || done1) check("drain_timeout", 1, 0);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        repeat (3) @(negedge clk);
        check("reset_busy", {511'b0, busy1}, '0);
        check("reset_done", {511'b0, done1}, '0);
        check("reset_result", res1, '0);
        check("reset_carry", {511'b0, cy1}, '0);
        resetn = 1'b1;
        @(negedge clk);

        issue1(2'b00, ALL1, ONE, 1'b1, '0, 1'b1);
        wait_drain1();
        issue1(2'b00, {384'b0, {128{1'b1}}}, ONE, 1'b1, ONE << 128, 1'b0);
        wait_drain1();
        issue1(2'b01, W'(5), W'(3), 1'b1, W'(2), 1'b0);
        wait_drain1();
        issue1(2'b01, W'(3), W'(5), 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b1);
        wait_drain1();
        issue1(2'b10, W'(3), W'(5), 1'b1, W'(3), 1'b1);
        wait_drain1();
        issue1(2'b10, ALL1, ALL1, 1'b1, '0, 1'b0);
        wait_drain1();
        issue1(2'b11, W'(7), W'(8), 1'b1, W'(15), 1'b0);
        wait_drain1();

        // Stray start two cycles into a run must be ignored.
        issue1(2'b00, W'(10), W'(20), 1'b1, W'(30), 1'b0);
        @(negedge clk);
        issue1(2'b01, W'(100), W'(1), 1'b0, '0, 1'b0);
        wait_drain1();

        // Back-to-back: second start lands in the DONE cycle.
        issue1(2'b01, W'(5), W'(3), 1'b1, W'(2), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("b2b_done_timeout", 1, 0);
        issue1(2'b00, ALL1, ALL1, 1'b1, {{(W-1){1'b1}}, 1'b0}, 1'b1);
        wait_drain1();

        // Abort in the second RUN cycle: no done, outputs back at reset values.
        issue1(2'b00, ALL1, ONE, 1'b0, '0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_busy", {511'b0, busy1}, '0);
        check("abort_done", {511'b0, done1}, '0);
        check("abort_result", res1, '0);
        check("abort_carry", {511'b0, cy1}, '0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);

        // Single-slice instance: done one cycle after start.
        start2 = 1'b1;
        mode2 = 2'b00;
        a2 = ALL1;
        b2 = ONE;
        e.res = '0; e.cy = 1'b1; e.c0 = cyc + 1; e.lat = 1;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        repeat (6) @(negedge clk);

        if (q1.size() != 0) check("q1_leftover", W'(q1.size()), '0);
        if (q2.size() != 0) check("q2_leftover", W'(q2.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Parametrised multi-cycle multi-precision adder/subtractor for the Montgomery datapath. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per cycle, through a single shared CHUNK-bit adder. It supports plain add, plain subtract, and conditional subtract (the final `t >= M ? t-M : t` reduction step). It replaces fixed-width, hand-sliced adders with a start/done handshake usable by the exponentiation controller.

## Interface
- WIDTH, 512: operand/result width in bits.
- CHUNK, 128: slice width processed per cycle. WIDTH % CHUNK must equal 0, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only when not busy
- mode  in  2  00 add, 01 sub, 10 cond-sub, 11 reserved (treated as add)
- in_a  in  WIDTH  operand A, latched at accepted start
- in_b  in  WIDTH  operand B (modulus for cond-sub), latched at accepted start
- busy  out  1  high while slices are being processed
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result, held until next accepted start
- carry_out  out  1  add: final carry; sub/cond-sub: borrow (1 ⇔ A < B)

## Operation
- FSM states:
  - IDLE: start=1 → RUN; latch in_a, in_b, mode; idx=0; cin = (mode≠add).
  - RUN: compute slice idx: {c, s} = a[idx] + (sub ? ~b[idx] : b[idx]) + cin. Write s into result slice idx, set cin=c, idx++. When idx = NCHUNK-1, go to DONE.
  - DONE: done=1 for this cycle. start=1 is accepted exactly as in IDLE, otherwise go to IDLE.
- Final slice:
  - carry_out = c for add, ~c for sub/cond-sub.
  - Cond-sub with borrow: result ← latched A (whole word) on the same edge; no extra cycle.
- Arithmetic is modulo 2^WIDTH; the overflow/borrow bit appears only on carry_out.
- start while busy is ignored; latched operands are not disturbed.
- mode=11 behaves as add.
- Reset values: busy 0, done 0, result 0, carry_out 0, state IDLE, idx 0, cin 0.
- resetn low mid-operation aborts the operation. No done is produced and all outputs are at reset values on the next cycle.

## Timing
- Start accepted at edge E0. Slices 0..NCHUNK-1 are written at edges E1..E_NCHUNK.
- done and final result/carry_out are valid in the cycle after edge E_NCHUNK.
- Latency: NCHUNK cycles from start edge to done.
- busy is high from E0 until the edge that enters DONE (NCHUNK cycles) and low during DONE.
- Back-to-back: start during DONE is accepted, giving a throughput of one operation per NCHUNK+1 cycles. A start in the DONE cycle overlaps nothing.
- CHUNK=WIDTH: single RUN cycle, so done arrives 1 cycle after start.
- Partial result slices change during RUN. result is only defined while done=1 or after DONE.
- Critical path: one CHUNK-bit adder plus a slice mux. Only idx, cin and mode are registered between slices.

## Structure
- Shared package mp_pkg holds:
  - mode encodings MODE_ADD, MODE_SUB, MODE_CSUB;
  - FSM state encoding ST_IDLE, ST_RUN, ST_DONE;
  - a clog2-based width function for idx.
- Sub-module mp_chunk_add: combinational CHUNK-bit add with an invert-B control, cin and cout.
- Top level holds the FSM, operand registers, slice select and result register.

## Test plan
All scenarios use WIDTH=512, CHUNK=128 unless stated.
- Add, A=2^512−1, B=1 → result 0, carry_out 1, done exactly 4 cycles after start.
- Cross-slice carry, add A=2^128−1, B=1 → result 2^128, carry_out 0.
- Sub, A=5, B=3 → result 2, carry_out 0. Sub, A=3, B=5 → result 2^512−2, carry_out 1.
- Cond-sub, A=3, B=5 → result 3, carry_out 1. Cond-sub, A=B=0xFFFF…F (512 bits) → result 0, carry_out 0.
- Second start pulsed 2 cycles into an operation is ignored and the first result is correct. A start during DONE is accepted, with done again 4 cycles later.
- resetn low in RUN cycle 2 → busy, done, result, carry_out all 0 next cycle, no done pulse. Repeat the add-with-carry case with CHUNK=512 → done 1 cycle after start.
